spi_reg_responder: RTL and testbench



---
 rtl/spi_reg_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_reg_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: far-end command responder for the 64-bit SPI terminal link.
// Consumes one command frame from the SPI slave receive side, runs it as a
// write, read or echo on the local register bus, and returns a 64-bit response
// frame through the SPI master transmit side. One command is in flight at a time.
module spi_reg_responder #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter bit          WRITE_ACK   = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        RX_VALID,
    input  logic [63:0] RX_DATA,
    output logic        RX_RD,
    input  logic        TX_BUSY,
    output logic        TX_WR,
    output logic [63:0] TX_DATA,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [15:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    input  logic [31:0] BUS_RDATA,
    input  logic        BUS_ACK,
    output logic [7:0]  ERR_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACK1   = 3'd1,
        S_ACK2   = 3'd2,
        S_DECODE = 3'd3,
        S_BUS    = 3'd4,
        S_RESP   = 3'd5,
        S_SENT   = 3'd6
    } state_t;

    localparam logic [1:0]  OP_WRITE  = 2'd0;
    localparam logic [1:0]  OP_READ   = 2'd1;
    localparam logic [1:0]  OP_ECHO   = 2'd2;
    localparam logic [1:0]  ST_OK     = 2'd0;
    localparam logic [1:0]  ST_BADOP  = 2'd1;
    localparam logic [1:0]  ST_TMO    = 2'd2;
    // Last wait-counter value before giving up; an ACK in that same cycle still wins.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 32'd1);

    // Saturating 8-bit increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            return 8'hFF;
        end else begin
            return val + 8'd1;
        end
    endfunction

    state_t      state_r,     state_s;
    logic [31:0] cmd_data_r,  cmd_data_s;
    logic [1:0]  cmd_op_r,    cmd_op_s;
    logic [15:0] cmd_addr_r,  cmd_addr_s;
    logic [31:0] resp_data_r, resp_data_s;
    logic [1:0]  status_r,    status_s;
    logic [15:0] wait_cnt_r,  wait_cnt_s;
    logic        rx_rd_r,     rx_rd_s;
    logic        tx_wr_r,     tx_wr_s;
    logic [63:0] tx_data_r,   tx_data_s;
    logic        bus_req_r,   bus_req_s;
    logic        bus_we_r,    bus_we_s;
    logic [15:0] bus_addr_r,  bus_addr_s;
    logic [31:0] bus_wdata_r, bus_wdata_s;
    logic [7:0]  err_count_r, err_count_s;
    logic        err_inc_s;

    // The frame bits between op and data carry no meaning for this block.
    logic unused_rx_bits_s;
    assign unused_rx_bits_s = ^RX_DATA[31:18];

    // Next-state and next-output logic for the command FSM.
    always_comb begin
        state_s     = state_r;
        cmd_data_s  = cmd_data_r;
        cmd_op_s    = cmd_op_r;
        cmd_addr_s  = cmd_addr_r;
        resp_data_s = resp_data_r;
        status_s    = status_r;
        wait_cnt_s  = wait_cnt_r;
        rx_rd_s     = rx_rd_r;
        tx_wr_s     = 1'b0;
        tx_data_s   = tx_data_r;
        bus_req_s   = bus_req_r;
        bus_we_s    = bus_we_r;
        bus_addr_s  = bus_addr_r;
        bus_wdata_s = bus_wdata_r;
        err_inc_s   = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (RX_VALID) begin
                    cmd_data_s = RX_DATA[63:32];
                    cmd_op_s   = RX_DATA[17:16];
                    cmd_addr_s = RX_DATA[15:0];
                    rx_rd_s    = 1'b1;
                    state_s    = S_ACK1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ACK1: begin
                state_s = S_ACK2;
            end
            S_ACK2: begin
                rx_rd_s = 1'b0;
                state_s = S_DECODE;
            end
            S_DECODE: begin
                resp_data_s = cmd_data_r;
                case (cmd_op_r)
                    OP_WRITE, OP_READ: begin
                        bus_req_s   = 1'b1;
                        bus_we_s    = (cmd_op_r == OP_WRITE);
                        bus_addr_s  = cmd_addr_r;
                        bus_wdata_s = cmd_data_r;
                        wait_cnt_s  = 16'd0;
                        state_s     = S_BUS;
                    end
                    OP_ECHO: begin
                        status_s = ST_OK;
                        state_s  = S_RESP;
                    end
                    default: begin
                        status_s  = ST_BADOP;
                        err_inc_s = 1'b1;
                        state_s   = S_RESP;
                    end
                endcase
            end
            S_BUS: begin
                if (BUS_ACK) begin
                    bus_req_s = 1'b0;
                    status_s  = ST_OK;
                    if (cmd_op_r == OP_READ) begin
                        resp_data_s = BUS_RDATA;
                    end else begin
                        resp_data_s = cmd_data_r;
                    end
                    if ((cmd_op_r == OP_WRITE) && !WRITE_ACK) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_RESP;
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    bus_req_s = 1'b0;
                    status_s  = ST_TMO;
                    err_inc_s = 1'b1;
                    state_s   = S_RESP;
                end else begin
                    wait_cnt_s = wait_cnt_r + 16'd1;
                end
            end
            S_RESP: begin
                if (!TX_BUSY) begin
                    tx_data_s = {resp_data_r, 1'b1, 11'd0, status_r, cmd_op_r, cmd_addr_r};
                    tx_wr_s   = 1'b1;
                    state_s   = S_SENT;
                end else begin
                    state_s = S_RESP;
                end
            end
            S_SENT: begin
                state_s = S_IDLE;
            end
            default: begin
                rx_rd_s   = 1'b0;
                bus_req_s = 1'b0;
                state_s   = S_IDLE;
            end
        endcase

        if (err_inc_s) begin
            err_count_s = sat_inc8(err_count_r);
        end else begin
            err_count_s = err_count_r;
        end
    end

    // State and registered outputs; reset drops any in-flight command.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= S_IDLE;
            cmd_data_r  <= 32'd0;
            cmd_op_r    <= 2'd0;
            cmd_addr_r  <= 16'd0;
            resp_data_r <= 32'd0;
            status_r    <= 2'd0;
            wait_cnt_r  <= 16'd0;
            rx_rd_r     <= 1'b0;
            tx_wr_r     <= 1'b0;
            tx_data_r   <= 64'd0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 16'd0;
            bus_wdata_r <= 32'd0;
            err_count_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            cmd_data_r  <= cmd_data_s;
            cmd_op_r    <= cmd_op_s;
            cmd_addr_r  <= cmd_addr_s;
            resp_data_r <= resp_data_s;
            status_r    <= status_s;
            wait_cnt_r  <= wait_cnt_s;
            rx_rd_r     <= rx_rd_s;
            tx_wr_r     <= tx_wr_s;
            tx_data_r   <= tx_data_s;
            bus_req_r   <= bus_req_s;
            bus_we_r    <= bus_we_s;
            bus_addr_r  <= bus_addr_s;
            bus_wdata_r <= bus_wdata_s;
            err_count_r <= err_count_s;
        end
    end

    assign RX_RD     = rx_rd_r;
    assign TX_WR     = tx_wr_r;
    assign TX_DATA   = tx_data_r;
    assign BUS_REQ   = bus_req_r;
    assign BUS_WE    = bus_we_r;
    assign BUS_ADDR  = bus_addr_r;
    assign BUS_WDATA = bus_wdata_r;
    assign ERR_COUNT = err_count_r;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: a table of command frames with hand-derived
// response frames, a timing model that predicts the TX_WR cycle of each
// response, and a scoreboard queue per DUT popped when TX_WR is seen.
// dut acknowledges writes; dut0 posts them silently; both share the inputs.
module tb_spi_reg_responder;

    localparam int TMO = 4;

    logic        CLK;
    logic        RESET_N;
    logic        RX_VALID;
    logic [63:0] RX_DATA;
    logic        TX_BUSY;
    logic [31:0] BUS_RDATA;
    logic        BUS_ACK;

    logic        RX_RD,  RX_RD0;
    logic        TX_WR,  TX_WR0;
    logic [63:0] TX_DATA, TX_DATA0;
    logic        BUS_REQ, BUS_REQ0;
    logic        BUS_WE,  BUS_WE0;
    logic [15:0] BUS_ADDR, BUS_ADDR0;
    logic [31:0] BUS_WDATA, BUS_WDATA0;
    logic [7:0]  ERR_COUNT, ERR_COUNT0;

    spi_reg_responder #(.TIMEOUT_CYC(TMO), .WRITE_ACK(1'b1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_RD(RX_RD),
        .TX_BUSY(TX_BUSY), .TX_WR(TX_WR), .TX_DATA(TX_DATA),
        .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
        .ERR_COUNT(ERR_COUNT)
    );

    spi_reg_responder #(.TIMEOUT_CYC(TMO), .WRITE_ACK(1'b0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N),
        .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_RD(RX_RD0),
        .TX_BUSY(TX_BUSY), .TX_WR(TX_WR0), .TX_DATA(TX_DATA0),
        .BUS_REQ(BUS_REQ0), .BUS_WE(BUS_WE0), .BUS_ADDR(BUS_ADDR0),
        .BUS_WDATA(BUS_WDATA0), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
        .ERR_COUNT(ERR_COUNT0)
    );

    typedef struct {
        logic [63:0] frame;
        int          ack_wait;   // BUS cycles before ACK; -1 = never
        logic [31:0] rdata;
        int          busy;       // RESP cycles with TX_BUSY high
        bit          pend;       // present pend_frame during BUS
        logic [63:0] pend_frame;
        logic [63:0] exp;        // expected response frame
    } vec_t;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        q0[$];
    vec_t        vecs[11];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  err_exp = 8'd0;
    logic [63:0] prev_tx = 64'd0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Response monitor: every TX_WR must match the head of its scoreboard.
    always begin
        exp_t e;
        @(posedge CLK);
        cyc++;
        #1;
        if (TX_WR) begin
            chk("tx_wr_while_busy", 64'(TX_BUSY), 64'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: TX_WR with TX_DATA=%h, required no send", TX_DATA);
            end else begin
                e = q.pop_front();
                chk("tx_data", TX_DATA, e.data);
                chk("tx_cycle", 64'(cyc), 64'(e.cyc));
                prev_tx = e.data;
            end
        end
        if (TX_WR0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx0_unexpected: TX_WR with TX_DATA=%h, required no send", TX_DATA0);
            end else begin
                e = q0.pop_front();
                chk("tx0_data", TX_DATA0, e.data);
                chk("tx0_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic run_cmd(input vec_t v);
        logic [1:0] op;
        bit         is_bus;
        bit         tmo;
        int         nbus;
        int         e0;
        int         resp_cyc;
        int         txc;
        exp_t       e;
        op     = v.frame[17:16];
        is_bus = (op == 2'd0) || (op == 2'd1);
        tmo    = is_bus && ((v.ack_wait < 0) || (v.ack_wait >= TMO));
        nbus   = !is_bus ? 0 : (tmo ? TMO : v.ack_wait + 1);

        @(negedge CLK);
        RX_DATA   = v.frame;
        RX_VALID  = 1'b1;
        TX_BUSY   = (v.busy > 0);
        BUS_RDATA = v.rdata;
        tick;
        e0 = cyc;
        chk("rx_rd_e0", 64'(RX_RD), 64'd1);
        chk("rx_rd0_e0", 64'(RX_RD0), 64'd1);
        @(negedge CLK);
        RX_VALID = 1'b0;
        tick;
        chk("rx_rd_e1", 64'(RX_RD), 64'd1);
        tick;
        chk("rx_rd_e2", 64'(RX_RD), 64'd0);

        resp_cyc = e0 + 3 + nbus;
        txc      = resp_cyc + v.busy + 1;
        e.data   = v.exp;
        e.cyc    = txc;
        q.push_back(e);
        if (!((op == 2'd0) && !tmo)) q0.push_back(e);
        if ((v.exp[19:18] != 2'd0) && (err_exp != 8'hFF)) err_exp = err_exp + 8'd1;

        tick;
        chk("bus_req_e3", 64'(BUS_REQ), 64'(is_bus));
        chk("bus_req0_e3", 64'(BUS_REQ0), 64'(is_bus));
        if (is_bus) begin
            chk("bus_we", 64'(BUS_WE), 64'(op == 2'd0));
            chk("bus_addr", 64'(BUS_ADDR), 64'(v.frame[15:0]));
            if (op == 2'd0) chk("bus_wdata", 64'(BUS_WDATA), 64'(v.frame[63:32]));
            for (int i = 0; i < nbus; i++) begin
                @(negedge CLK);
                BUS_ACK = !tmo && (i == v.ack_wait);
                if (v.pend && (i == 0)) begin
                    RX_DATA  = v.pend_frame;
                    RX_VALID = 1'b1;
                end
                tick;
                if (i < nbus - 1) chk("bus_req_hold", 64'(BUS_REQ), 64'd1);
                else              chk("bus_req_fall", 64'(BUS_REQ), 64'd0);
                if (v.pend) chk("rx_rd_pending", 64'(RX_RD), 64'd0);
            end
            @(negedge CLK);
            BUS_ACK = 1'b0;
        end

        while (cyc < resp_cyc + v.busy) begin
            tick;
            chk("tx_wr_held_busy", 64'(TX_WR), 64'd0);
            chk("tx_data_stable", TX_DATA, prev_tx);
        end
        @(negedge CLK);
        TX_BUSY = 1'b0;
        while (cyc < txc + 1) tick;

        chk("tx_sent", 64'(q.size()), 64'd0);
        chk("tx0_sent", 64'(q0.size()), 64'd0);
        q.delete();
        q0.delete();
        chk("err_count", 64'(ERR_COUNT), 64'(err_exp));
        chk("err_count0", 64'(ERR_COUNT0), 64'(err_exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bad;
        // frame, ack_wait, rdata, busy, pend, pend_frame, expected response
        vecs[0]  = '{64'h00000000_00010012, 0,  32'hCAFEF00D, 0,  1'b0, 64'd0, 64'hCAFEF00D_80010012};
        vecs[1]  = '{64'h12345678_00000100, 3,  32'hFFFFFFFF, 0,  1'b0, 64'd0, 64'h12345678_80000100};
        vecs[2]  = '{64'hDEADBEEF_0002ABCD, 0,  32'h0,        0,  1'b0, 64'd0, 64'hDEADBEEF_8002ABCD};
        vecs[3]  = '{64'h00000001_00030001, 0,  32'h0,        0,  1'b0, 64'd0, 64'h00000001_80070001};
        vecs[4]  = '{64'h00000000_00010034, -1, 32'h13579BDF, 0,  1'b0, 64'd0, 64'h00000000_80090034};
        vecs[5]  = '{64'hA5A5A5A5_00000200, -1, 32'h0,        0,  1'b0, 64'd0, 64'hA5A5A5A5_80080200};
        vecs[6]  = '{64'h00000000_00010055, 1,  32'h11223344, 20, 1'b0, 64'd0, 64'h11223344_80010055};
        vecs[7]  = '{64'h0BADF00D_FFFE1234, 0,  32'h0,        0,  1'b0, 64'd0, 64'h0BADF00D_80021234};
        vecs[8]  = '{64'h00000000_00010077, 3,  32'h89ABCDEF, 0,  1'b0, 64'd0, 64'h89ABCDEF_80010077};
        vecs[9]  = '{64'h00000000_00010066, 2,  32'h0F0F0F0F, 0,  1'b1, 64'h55AA55AA_00020009,
                     64'h0F0F0F0F_80010066};
        vecs[10] = '{64'h55AA55AA_00020009, 0,  32'h0,        0,  1'b0, 64'd0, 64'h55AA55AA_80020009};

        RESET_N   = 1'b0;
        RX_VALID  = 1'b0;
        RX_DATA   = 64'd0;
        TX_BUSY   = 1'b0;
        BUS_RDATA = 32'd0;
        BUS_ACK   = 1'b0;
        repeat (3) tick;
        chk("rst_rx_rd", 64'(RX_RD), 64'd0);
        chk("rst_tx_wr", 64'(TX_WR), 64'd0);
        chk("rst_tx_data", TX_DATA, 64'd0);
        chk("rst_bus_req", 64'(BUS_REQ), 64'd0);
        chk("rst_bus_we", 64'(BUS_WE), 64'd0);
        chk("rst_bus_addr", 64'(BUS_ADDR), 64'd0);
        chk("rst_bus_wdata", 64'(BUS_WDATA), 64'd0);
        chk("rst_err_count", 64'(ERR_COUNT), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) tick;

        for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

        // Bad-op storm: the error counter must stop at 255.
        bad = '{64'h00000001_00030001, 0, 32'h0, 0, 1'b0, 64'd0, 64'h00000001_80070001};
        for (int i = 0; i < 300; i++) run_cmd(bad);
        chk("err_count_sat", 64'(ERR_COUNT), 64'd255);

        // Reset pulsed while a read waits on the bus: nothing may be sent.
        @(negedge CLK);
        RX_DATA  = 64'h00000000_00010042;
        RX_VALID = 1'b1;
        tick;
        @(negedge CLK);
        RX_VALID = 1'b0;
        repeat (4) tick;
        chk("bus_req_before_rst", 64'(BUS_REQ), 64'd1);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_rx_rd", 64'(RX_RD), 64'd0);
        chk("mid_rst_tx_wr", 64'(TX_WR), 64'd0);
        chk("mid_rst_tx_data", TX_DATA, 64'd0);
        chk("mid_rst_bus_req", 64'(BUS_REQ), 64'd0);
        chk("mid_rst_bus_we", 64'(BUS_WE), 64'd0);
        chk("mid_rst_bus_addr", 64'(BUS_ADDR), 64'd0);
        chk("mid_rst_bus_wdata", 64'(BUS_WDATA), 64'd0);
        chk("mid_rst_err_count", 64'(ERR_COUNT), 64'd0);
        chk("mid_rst_bus_req0", 64'(BUS_REQ0), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        err_exp = 8'd0;
        prev_tx = 64'd0;
        repeat (12) begin
            tick;
            chk("post_rst_bus_req", 64'(BUS_REQ), 64'd0);
        end

        // Recovery after reset: an ordinary echo must go through.
        run_cmd(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
